alu_issue: RTL and testbench

//  Decode/issue stage producing the ALU operation (rv32::fn_t) and both operands from a fetched RV32I word.

---
 rtl/rv32.sv | 19 +
 rtl/alu_issue.sv | 212 +++++++++++++++++++++
 tb/tb_alu_issue.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rv32.sv
// Shared RV32 definitions for the decode/issue stage and its consumers.
//   fn_t : ALU function selector carried from issue to execute.
package rv32;

    typedef enum logic [3:0] {
        FN_ADD,
        FN_SUB,
        FN_SLL,
        FN_SLT,
        FN_SLTU,
        FN_XOR,
        FN_SRL,
        FN_SRA,
        FN_OR,
        FN_AND,
        FN_OP2
    } fn_t;

endpackage

// File: rtl/alu_issue.sv
// alu_issue: decode/issue stage for RV32I OP, OP-IMM, LUI and AUIPC.
// Decodes one instruction word into an ALU function plus two operands,
// blocks read-after-write hazards with a pending-register scoreboard and
// hands one registered bundle per instruction to execute (valid/ready).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake for in_inst/in_pc
//   in_inst, in_pc        instruction word and its address
//   rs1_addr, rs2_addr    combinational regfile read addresses
//   rs1_data, rs2_data    regfile read data (write-first, same cycle)
//   wb_valid, wb_rd       writeback retiring register wb_rd
//   out_valid/out_ready   downstream handshake for the bundle
//   out_fn, out_op1/op2   ALU function and operands
//   out_rd, out_we        destination register and writeback enable
//   out_illegal           instruction not handled by this stage
module alu_issue
    import rv32::*;
#(
    parameter int SCOREBOARD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output fn_t         out_fn,
    output logic [31:0] out_op1,
    output logic [31:0] out_op2,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    fn_t         d_fn;
    logic [31:0] d_op1;
    logic [31:0] d_op2;
    logic [4:0]  d_rd;
    logic        d_legal;
    logic        d_we;
    logic        use_rs1;
    logic        use_rs2;

    logic [31:0] pending;
    logic [31:0] clr;
    logic [31:0] pend_eff;
    logic [31:0] set_vec;
    logic [31:0] pend_next;
    logic        stall;
    logic        accept;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign funct7   = in_inst[31:25];
    assign rd_field = in_inst[11:7];
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    // x0 is hard-wired to zero whatever the register file returns.
    assign rs1_val = (rs1_addr == 5'd0) ? 32'd0 : rs1_data;
    assign rs2_val = (rs2_addr == 5'd0) ? 32'd0 : rs2_data;

    function automatic fn_t alu_fn(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_fn = alt ? FN_SUB : FN_ADD;
            3'b001:  alu_fn = FN_SLL;
            3'b010:  alu_fn = FN_SLT;
            3'b011:  alu_fn = FN_SLTU;
            3'b100:  alu_fn = FN_XOR;
            3'b101:  alu_fn = alt ? FN_SRA : FN_SRL;
            3'b110:  alu_fn = FN_OR;
            default: alu_fn = FN_AND;
        endcase
    endfunction

    // Decode. An illegal word is squashed into a harmless ADD 0,0 with no
    // destination and no source usage, so it never stalls or sets pending.
    always_comb begin
        d_fn    = FN_ADD;
        d_op1   = 32'd0;
        d_op2   = 32'd0;
        d_rd    = rd_field;
        d_legal = 1'b1;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                d_op1   = rs1_val;
                d_op2   = rs2_val;
                if (funct7 == F7_ZERO ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))
                    d_fn = alu_fn(funct3, funct7[5]);
                else
                    d_legal = 1'b0;
            end
            OPC_OP_IMM: begin
                use_rs1 = 1'b1;
                d_op1   = rs1_val;
                d_op2   = {{20{in_inst[31]}}, in_inst[31:20]};
                if (funct3 == 3'b001) begin
                    d_op2 = {27'd0, in_inst[24:20]};
                    d_fn  = FN_SLL;
                    if (funct7 != F7_ZERO)
                        d_legal = 1'b0;
                end else if (funct3 == 3'b101) begin
                    d_op2 = {27'd0, in_inst[24:20]};
                    if (funct7 == F7_ZERO)
                        d_fn = FN_SRL;
                    else if (funct7 == F7_ALT)
                        d_fn = FN_SRA;
                    else
                        d_legal = 1'b0;
                end else begin
                    // Immediate ADD never becomes SUB.
                    d_fn = alu_fn(funct3, 1'b0);
                end
            end
            OPC_LUI: begin
                d_fn  = FN_OP2;
                d_op2 = {in_inst[31:12], 12'd0};
            end
            OPC_AUIPC: begin
                d_fn  = FN_ADD;
                d_op1 = in_pc;
                d_op2 = {in_inst[31:12], 12'd0};
            end
            default: d_legal = 1'b0;
        endcase
        if (!d_legal) begin
            d_fn    = FN_ADD;
            d_op1   = 32'd0;
            d_op2   = 32'd0;
            d_rd    = 5'd0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
    end

    assign d_we = d_legal && (d_rd != 5'd0);

    // A register retiring this cycle no longer blocks its readers because
    // the register file forwards the write to the read port.
    assign clr      = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign pend_eff = pending & ~clr;
    assign stall    = in_valid && ((use_rs1 && pend_eff[rs1_addr]) ||
                                   (use_rs2 && pend_eff[rs2_addr]));

    assign in_ready = !reset && !stall && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Setting after clearing lets a new writer of rd win over a retiring one.
    assign set_vec   = (accept && d_we) ? (32'd1 << d_rd) : 32'd0;
    assign pend_next = pend_eff | set_vec;

    // Output bundle register: load on accept, drop valid once consumed,
    // otherwise hold every field stable for the execute stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_fn      <= FN_ADD;
            out_op1     <= 32'd0;
            out_op2     <= 32'd0;
            out_rd      <= 5'd0;
            out_we      <= 1'b0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_fn      <= d_fn;
            out_op1     <= d_op1;
            out_op2     <= d_op2;
            out_rd      <= d_rd;
            out_we      <= d_we;
            out_illegal <= !d_legal;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // Scoreboard of registers with an in-flight writer; x0 never pending.
    always_ff @(posedge clk) begin
        if (reset || SCOREBOARD == 0)
            pending <= 32'd0;
        else
            pending <= {pend_next[31:1], 1'b0};
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue: one task per scenario, inline checks.
module tb_alu_issue;
    import rv32::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        out_valid;
    logic        out_ready;
    fn_t         out_fn;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [32];

    always #5 clk = ~clk;

    // Register file model; x0 deliberately holds garbage.
    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    alu_issue #(.SCOREBOARD(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fn(out_fn), .out_op1(out_op1), .out_op2(out_op2),
        .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
        wb_valid = 1'b0; wb_rd = 5'd0; out_ready = 1'b1;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b want 0", out_valid); end
        checks++; if (out_fn !== FN_ADD) begin errors++; $display("[TB] FAIL reset_fn: got %0d want %0d", out_fn, FN_ADD); end
        checks++; if (out_op1 !== 32'd0 || out_op2 !== 32'd0) begin errors++; $display("[TB] FAIL reset_ops: got %h %h want 0 0", out_op1, out_op2); end
        checks++; if (out_rd !== 5'd0 || out_we !== 1'b0 || out_illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_we_ill: got %0d %0b %0b want 0 0 0", out_rd, out_we, out_illegal); end
        checks++; if (dut.pending !== 32'd0) begin errors++; $display("[TB] FAIL reset_pending: got %h want 0", dut.pending); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b want 0", in_ready); end
        reset = 1'b0;
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_inst = 32'hFFF00093;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL addi_ready: got %0b want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_fn !== FN_ADD) begin errors++; $display("[TB] FAIL addi_fn: got v=%0b fn=%0d want v=1 fn=%0d", out_valid, out_fn, FN_ADD); end
        checks++; if (out_op1 !== 32'd0 || out_op2 !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL addi_ops: got %h %h want 0 ffffffff", out_op1, out_op2); end
        checks++; if (out_rd !== 5'd1 || out_we !== 1'b1) begin errors++; $display("[TB] FAIL addi_rd_we: got %0d %0b want 1 1", out_rd, out_we); end
        checks++; if (dut.pending !== 32'h2) begin errors++; $display("[TB] FAIL addi_pending: got %h want 2", dut.pending); end
    endtask

    task automatic test_stall();
        in_inst = 32'h4040D113;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready%0d: got %0b want 0", i, in_ready); end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_bubble: got %0b want 0", out_valid); end
        wb_valid = 1'b1; wb_rd = 5'd1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_release: got %0b want 1", in_ready); end
        step();
        wb_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_fn !== FN_SRA) begin errors++; $display("[TB] FAIL srai_fn: got v=%0b fn=%0d want v=1 fn=%0d", out_valid, out_fn, FN_SRA); end
        checks++; if (out_op1 !== 32'h01010101 || out_op2 !== 32'd4) begin errors++; $display("[TB] FAIL srai_ops: got %h %h want 01010101 4", out_op1, out_op2); end
        checks++; if (out_rd !== 5'd2 || out_we !== 1'b1) begin errors++; $display("[TB] FAIL srai_rd_we: got %0d %0b want 2 1", out_rd, out_we); end
        checks++; if (dut.pending !== 32'h4) begin errors++; $display("[TB] FAIL srai_pending: got %h want 4", dut.pending); end
    endtask

    task automatic test_back_to_back();
        in_inst = 32'h123451B7;
        step();
        checks++; if (out_fn !== FN_OP2 || out_op1 !== 32'd0 || out_op2 !== 32'h12345000 || out_rd !== 5'd3) begin errors++; $display("[TB] FAIL lui: got fn=%0d %h %h rd=%0d want fn=%0d 0 12345000 rd=3", out_fn, out_op1, out_op2, out_rd, FN_OP2); end
        in_inst = 32'h00001217; in_pc = 32'h100;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL auipc_ready: got %0b want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_fn !== FN_ADD || out_op1 !== 32'h100 || out_op2 !== 32'h1000 || out_rd !== 5'd4) begin errors++; $display("[TB] FAIL auipc: got v=%0b fn=%0d %h %h rd=%0d want v=1 fn=%0d 100 1000 rd=4", out_valid, out_fn, out_op1, out_op2, out_rd, FN_ADD); end
        checks++; if (dut.pending !== 32'h1C) begin errors++; $display("[TB] FAIL auipc_pending: got %h want 1c", dut.pending); end
    endtask

    task automatic test_hold();
        out_ready = 1'b0; in_inst = 32'h12306293; in_pc = 32'h104;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_ready%0d: got %0b want 0", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || out_fn !== FN_ADD || out_op1 !== 32'h100 || out_op2 !== 32'h1000 || out_rd !== 5'd4 || out_we !== 1'b1) begin errors++; $display("[TB] FAIL hold_stable%0d: got v=%0b fn=%0d %h %h rd=%0d we=%0b", i, out_valid, out_fn, out_op1, out_op2, out_rd, out_we); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_release: got %0b want 1", in_ready); end
        step();
        checks++; if (out_fn !== FN_OR || out_op1 !== 32'd0 || out_op2 !== 32'h123 || out_rd !== 5'd5 || out_we !== 1'b1) begin errors++; $display("[TB] FAIL ori: got fn=%0d %h %h rd=%0d we=%0b want fn=%0d 0 123 rd=5 we=1", out_fn, out_op1, out_op2, out_rd, out_we, FN_OR); end
    endtask

    task automatic test_illegal();
        in_inst = 32'h00000000;
        step();
        checks++; if (out_illegal !== 1'b1 || out_we !== 1'b0 || out_fn !== FN_ADD || out_op1 !== 32'd0 || out_op2 !== 32'd0 || out_rd !== 5'd0) begin errors++; $display("[TB] FAIL ill_zero: got ill=%0b we=%0b fn=%0d %h %h rd=%0d", out_illegal, out_we, out_fn, out_op1, out_op2, out_rd); end
        checks++; if (dut.pending !== 32'h3C) begin errors++; $display("[TB] FAIL ill_zero_pending: got %h want 3c", dut.pending); end
        in_inst = 32'h027302B3;
        step();
        checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_we !== 1'b0 || out_rd !== 5'd0 || out_op1 !== 32'd0) begin errors++; $display("[TB] FAIL ill_mul: got v=%0b ill=%0b we=%0b rd=%0d op1=%h", out_valid, out_illegal, out_we, out_rd, out_op1); end
        checks++; if (dut.pending !== 32'h3C) begin errors++; $display("[TB] FAIL ill_mul_pending: got %h want 3c", dut.pending); end
        in_inst = 32'h00208033;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL add_x0_stall: got %0b want 0", in_ready); end
        step();
        wb_valid = 1'b1; wb_rd = 5'd2;
        step();
        wb_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b0 || out_fn !== FN_ADD || out_op1 !== 32'h01010101 || out_op2 !== 32'h02020202) begin errors++; $display("[TB] FAIL add_x0: got v=%0b ill=%0b fn=%0d %h %h", out_valid, out_illegal, out_fn, out_op1, out_op2); end
        checks++; if (out_rd !== 5'd0 || out_we !== 1'b0) begin errors++; $display("[TB] FAIL add_x0_we: got rd=%0d we=%0b want 0 0", out_rd, out_we); end
        checks++; if (dut.pending !== 32'h38) begin errors++; $display("[TB] FAIL add_x0_pending: got %h want 38", dut.pending); end
        in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd7;
        step();
        wb_valid = 1'b0;
        checks++; if (dut.pending !== 32'h38) begin errors++; $display("[TB] FAIL wb_nonpending: got %h want 38", dut.pending); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00001437;
        step();
        in_inst = 32'h00118313;
        #1;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_setup: got v=%0b rdy=%0b want 1 0", out_valid, in_ready); end
        reset = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || dut.pending !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset: got v=%0b pending=%h want 0 0", out_valid, dut.pending); end
        checks++; if (out_fn !== FN_ADD || out_op1 !== 32'd0 || out_op2 !== 32'd0 || out_rd !== 5'd0 || out_we !== 1'b0 || out_illegal !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_outs: got fn=%0d %h %h rd=%0d we=%0b ill=%0b", out_fn, out_op1, out_op2, out_rd, out_we, out_illegal); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ready: got %0b want 0", in_ready); end
        reset = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %0b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_fn !== FN_ADD || out_op1 !== 32'h03030303 || out_op2 !== 32'd1 || out_rd !== 5'd6) begin errors++; $display("[TB] FAIL post_reset_addi: got v=%0b fn=%0d %h %h rd=%0d", out_valid, out_fn, out_op1, out_op2, out_rd); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h01010101 * i;
        rf[0] = 32'hDEADBEEF;
        test_reset();
        test_addi();
        test_stall();
        test_back_to_back();
        test_hold();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
